// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer engine: FSM state encoding and
// the output shift/ReLU/saturate stage.
package nn_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StCompute,
      StOut
   } nn_state_e;

   localparam int NN_DW      = 8;
   localparam int NN_OUT_MAX = 127;

   // Arithmetic shift, then clamp negative results to 0 and large ones to NN_OUT_MAX.
   function automatic logic [NN_DW-1:0] sat_relu(input logic signed [31:0] acc,
                                                 input int unsigned       shift);
      logic signed [31:0] r;
      r = acc >>> shift;
      if (r < 0) begin
         return '0;
      end else if (r > NN_OUT_MAX) begin
         return NN_DW'(NN_OUT_MAX);
      end
      return r[NN_DW-1:0];
   endfunction

endpackage

// File: rtl/nn_dense_layer_mac.sv
// Single signed 8x8 multiply-accumulate register. clr preloads the sign-extended
// bias, en adds one sign-extended product per cycle.
module nn_mac #(
   parameter int unsigned ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [7:0]       init,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic [ACC_W-1:0] acc
);

   logic signed [15:0] prod;

   assign prod = signed'(a) * signed'(b);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= {{(ACC_W-8){init[7]}}, init};
      end else if (en) begin
         acc <= acc + {{(ACC_W-16){prod[15]}}, prod};
      end
   end

endmodule

// File: rtl/nn_dense_layer.sv
// Fully connected layer: buffers one int8 input vector, then computes each neuron
// with a single MAC over N_IN cycles and streams the clamped results out.
module nn_dense_layer
   import nn_pkg::*;
#(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned ACC_W = 24,
   parameter int unsigned SHIFT = 0,
   parameter int unsigned WA_W  = $clog2(N_IN*N_OUT+N_OUT),
   localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
   localparam int unsigned I_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wr_en,
   input  logic [WA_W-1:0]  wr_addr,
   input  logic [7:0]       wr_data,
   output logic             wr_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned N_W   = N_IN * N_OUT;
   localparam int unsigned N_PAR = N_W + N_OUT;

   nn_state_e        state_q;
   logic [I_W-1:0]   i_q;
   logic [IDX_W-1:0] j_q;
   logic [7:0]       x_q   [N_IN];
   logic [7:0]       par_q [N_PAR];
   logic             wr_err_q;

   logic             in_accept;
   logic             out_hs;
   logic             last_i;
   logic             last_j;
   logic             load_done;
   logic             wr_legal;
   logic             mac_clr;
   logic             mac_en;
   logic [7:0]       mac_init;
   logic [7:0]       mac_a;
   logic [7:0]       mac_b;
   logic [ACC_W-1:0] acc;
   logic [WA_W-1:0]  w_idx;
   logic [WA_W-1:0]  b_idx;
   int unsigned      b_sel;

   // All outputs derive from registered state only.
   assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StOut);
   assign out_idx   = j_q;
   assign last_j    = (j_q == IDX_W'(N_OUT - 1));
   assign out_last  = out_valid && last_j;
   assign out_data  = sat_relu(32'(signed'(acc)), SHIFT);
   assign wr_err    = wr_err_q;

   assign in_accept = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign last_i    = (i_q == I_W'(N_IN - 1));
   assign load_done = in_accept && (((state_q == StIdle) && (N_IN == 1)) ||
                                    ((state_q == StLoad) && last_i));
   assign wr_legal  = wr_en && !busy && (32'(wr_addr) < N_PAR);

   // The bias for the next neuron is preloaded on the cycle that enters COMPUTE.
   always_comb begin
      b_sel = 0;
      if (!load_done && !last_j) begin
         b_sel = 32'(j_q) + 1;
      end
      b_idx = WA_W'(N_W + b_sel);
      w_idx = WA_W'(32'(j_q) * N_IN + 32'(i_q));
   end

   assign mac_clr  = load_done || (out_hs && !last_j);
   assign mac_en   = (state_q == StCompute);
   assign mac_init = par_q[b_idx];
   assign mac_a    = x_q[i_q];
   assign mac_b    = par_q[w_idx];

   nn_mac #(
      .ACC_W(ACC_W)
   ) u_mac (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .clr  (mac_clr),
      .en   (mac_en),
      .init (mac_init),
      .a    (mac_a),
      .b    (mac_b),
      .acc  (acc)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= StIdle;
         i_q      <= '0;
         j_q      <= '0;
         wr_err_q <= 1'b0;
         for (int k = 0; k < N_IN; k++) begin
            x_q[k] <= '0;
         end
         for (int k = 0; k < N_PAR; k++) begin
            par_q[k] <= '0;
         end
      end else begin
         wr_err_q <= wr_en && !wr_legal;
         if (wr_legal) begin
            par_q[wr_addr] <= wr_data;
         end

         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  x_q[0] <= in_data;
                  if (N_IN == 1) begin
                     i_q     <= '0;
                     j_q     <= '0;
                     state_q <= StCompute;
                  end else begin
                     i_q     <= I_W'(1);
                     state_q <= StLoad;
                  end
               end
            end
            StLoad: begin
               if (in_valid) begin
                  x_q[i_q] <= in_data;
                  if (last_i) begin
                     i_q     <= '0;
                     j_q     <= '0;
                     state_q <= StCompute;
                  end else begin
                     i_q <= i_q + 1'b1;
                  end
               end
            end
            StCompute: begin
               if (last_i) begin
                  i_q     <= '0;
                  state_q <= StOut;
               end else begin
                  i_q <= i_q + 1'b1;
               end
            end
            StOut: begin
               if (out_ready) begin
                  if (last_j) begin
                     j_q     <= '0;
                     state_q <= StIdle;
                  end else begin
                     j_q     <= j_q + 1'b1;
                     state_q <= StCompute;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_dense_layer.sv
// Scoreboarded bench for nn_dense_layer with N_IN=8, N_OUT=4, SHIFT=0.
module tb_nn_dense_layer;

   localparam int N_IN  = 8;
   localparam int N_OUT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_err;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_idx;
   logic       out_last;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int hs_cyc;

   // Expected output entries packed as {last, idx[1:0], data[7:0]}.
   logic [10:0] exp_q [$];

   nn_dense_layer #(
      .N_IN (N_IN),
      .N_OUT(N_OUT),
      .ACC_W(24),
      .SHIFT(0)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_err   (wr_err),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_idx  (out_idx),
      .out_last (out_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: every output handshake pops and checks one expected entry.
   always @(negedge clk) begin
      logic [10:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_idx), 32'hffff);
         end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[7:0]));
            check("out_idx", 32'(out_idx), 32'(e[9:8]));
            check("out_last", 32'(out_last), 32'(e[10]));
         end
      end
   end

   task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
      exp_q.push_back({1'b0, 2'd0, d0});
      exp_q.push_back({1'b0, 2'd1, d1});
      exp_q.push_back({1'b0, 2'd2, d2});
      exp_q.push_back({1'b1, 2'd3, d3});
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [7:0] data, input logic exp_err);
      wr_en   = 1'b1;
      wr_addr = 6'(addr);
      wr_data = data;
      cycle();
      wr_en = 1'b0;
      check("wr_err", 32'(wr_err), 32'(exp_err));
   endtask

   task automatic send(input logic [7:0] v);
      int  n;
      logic hs;
      n        = 0;
      in_valid = 1'b1;
      in_data  = v;
      do begin
         hs     = in_ready;
         hs_cyc = cyc;
         cycle();
         n++;
      end while (!hs && n < 100);
      in_valid = 1'b0;
      if (!hs) check("in_handshake_timeout", 0, 1);
   endtask

   task automatic feed(input int base, input int step);
      for (int i = 0; i < N_IN; i++) send(8'(base + i * step));
   endtask

   task automatic load_all(input logic [7:0] w, input logic [7:0] b);
      for (int a = 0; a < N_IN * N_OUT; a++) wr(a, w, 1'b0);
      for (int a = 0; a < N_OUT; a++) wr(N_IN * N_OUT + a, b, 1'b0);
   endtask

   task automatic load_diag();
      for (int a = 0; a < N_IN * N_OUT + N_OUT; a++)
         wr(a, (a < N_IN * N_OUT && a / N_IN == a % N_IN) ? 8'd1 : 8'd0, 1'b0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 400) begin
         cycle();
         n++;
      end
      check("idle_timeout", 32'(n < 400), 1);
   endtask

   task automatic wait_out(input logic [1:0] idx);
      int n;
      n = 0;
      while (!(out_valid && out_idx == idx) && n < 100) begin
         cycle();
         n++;
      end
      check("out_wait_timeout", 32'(n < 100), 1);
   endtask

   initial begin
      int n;
      int u;
      rst       = 1'b1;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_idx", 32'(out_idx), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_err", 32'(wr_err), 0);

      // 1: cleared parameters give all-zero outputs
      push4(8'd0, 8'd0, 8'd0, 8'd0);
      feed(5, 0);
      wait_idle();

      // 2: diagonal weights, plus first-output latency
      load_diag();
      push4(8'd1, 8'd2, 8'd3, 8'd4);
      feed(1, 1);
      n = 0;
      while (!out_valid && n < 50) begin
         cycle();
         n++;
      end
      check("first_valid_latency", 32'(cyc - hs_cyc), 9);
      wait_idle();

      // 4: backpressure on neuron 1
      push4(8'd10, 8'd20, 8'd30, 8'd40);
      feed(10, 10);
      wait_out(2'd1);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("bp_valid", 32'(out_valid), 1);
         check("bp_data", 32'(out_data), 20);
         check("bp_idx", 32'(out_idx), 1);
      end
      out_ready = 1'b1;
      u = cyc;
      cycle();
      n = 0;
      while (!out_valid && n < 50) begin
         cycle();
         n++;
      end
      check("bp_next_latency", 32'(cyc - u), 9);
      wait_idle();

      // 5: dropped writes
      push4(8'd1, 8'd2, 8'd3, 8'd4);
      feed(1, 1);
      wr(0, 8'd50, 1'b1);
      wait_idle();
      push4(8'd1, 8'd2, 8'd3, 8'd4);
      feed(1, 1);
      wait_idle();
      wr(36, 8'd9, 1'b1);

      // 3: saturation high, then ReLU of a negative sum
      load_all(8'd127, 8'd0);
      push4(8'd127, 8'd127, 8'd127, 8'd127);
      feed(127, 0);
      wait_idle();
      load_all(8'hff, 8'd5);
      push4(8'd0, 8'd0, 8'd0, 8'd0);
      feed(10, 0);
      wait_idle();

      // 6: reset during neuron 2 compute
      load_diag();
      exp_q.push_back({1'b0, 2'd0, 8'd1});
      exp_q.push_back({1'b0, 2'd1, 8'd2});
      feed(1, 1);
      wait_out(2'd1);
      cycle();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
      check("midrst_out_valid", 32'(out_valid), 0);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) n++;
         cycle();
      end
      check("midrst_no_output", 32'(n), 0);
      check("midrst_queue", 32'(exp_q.size()), 0);
      push4(8'd0, 8'd0, 8'd0, 8'd0);
      feed(1, 1);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
